// File: rtl/ans_pkg.sv
// Shared encodings and parameter helpers for the streaming rANS encoder.
package ans_pkg;

    typedef enum logic [1:0] {
        CMD_IDLE  = 2'b00,
        CMD_LOAD  = 2'b01,
        CMD_ENC   = 2'b10,
        CMD_FLUSH = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RENORM = 3'd1,
        ST_DIVIDE = 3'd2,
        ST_UPDATE = 3'd3,
        ST_FLUSH  = 3'd4
    } state_e;

    // Lower bound of the normalised state interval.
    function automatic int unsigned ans_l(input int unsigned sw, input int unsigned dw);
        return 32'd1 << (sw - dw);
    endfunction

    // Total frequency count of a valid table.
    function automatic int unsigned ans_m(input int unsigned pb);
        return 32'd1 << pb;
    endfunction

endpackage

// File: rtl/ans_seq_div.sv
// Restoring divider, one quotient bit per cycle.
// Caller guarantees the dividend's upper DIVISOR_W bits are below the divisor.
module ans_seq_div #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [DIVIDEND_W-1:0]           dividend,
    input  logic [DIVISOR_W-1:0]            divisor,
    output logic                            busy,
    output logic                            done,
    output logic [DIVIDEND_W-DIVISOR_W-1:0] quot,
    output logic [DIVISOR_W-1:0]            rem
);
    localparam int QW = DIVIDEND_W - DIVISOR_W;
    localparam int CW = (QW > 1) ? $clog2(QW) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(QW - 1);

    logic                 busy_q, busy_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DIVISOR_W-1:0] rem_q, rem_d;
    logic [QW-1:0]        quo_q, quo_d;
    logic [DIVISOR_W-1:0] dvs_q, dvs_d;
    logic [DIVISOR_W:0]   trial;
    logic                 take;

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        trial  = {rem_q, quo_q[QW-1]};
        take   = (trial >= {1'b0, dvs_q});
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            rem_d  = dividend[DIVIDEND_W-1:QW];
            quo_d  = dividend[QW-1:0];
            dvs_d  = divisor;
        end else if (busy_q) begin
            // Dividend bits shift out of quo as quotient bits shift in.
            rem_d = take ? DIVISOR_W'(trial - {1'b0, dvs_q})
                         : trial[DIVISOR_W-1:0];
            quo_d = {quo_q[QW-2:0], take};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == CNT_LAST);
    assign quot = quo_q;
    assign rem  = rem_q;

endmodule

// File: rtl/ans_rans_encoder.sv
// Streaming rANS encoder: table load, renormalise, divide/update, flush.
module ans_rans_encoder
    import ans_pkg::*;
#(
    parameter int SYM_WIDTH   = 4,
    parameter int PROB_BITS   = 8,
    parameter int STATE_WIDTH = 16,
    parameter int DIGIT_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             cmd,
    input  logic [PROB_BITS-1:0]   in_data,
    input  logic                   in_vld,
    output logic                   in_rdy,
    output logic [DIGIT_WIDTH-1:0] out_data,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic                   out_last,
    output logic                   table_ok,
    output logic                   table_err,
    output logic                   sym_err
);
    localparam int NSYM = 1 << SYM_WIDTH;
    localparam int K    = STATE_WIDTH - PROB_BITS;
    localparam int NDIG = STATE_WIDTH / DIGIT_WIDTH;
    localparam int SUMW = PROB_BITS + SYM_WIDTH;
    localparam int DCW  = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [STATE_WIDTH-1:0] L =
        STATE_WIDTH'(ans_l(STATE_WIDTH, DIGIT_WIDTH));
    localparam logic [SUMW-1:0] M = SUMW'(ans_m(PROB_BITS));
    localparam logic [SYM_WIDTH-1:0] PTR_LAST = '1;
    localparam logic [DCW-1:0] DIG_LAST = DCW'(NDIG - 1);
    localparam logic [DCW-1:0] DIG_PEN  = DCW'(NDIG - 2);

    function automatic logic [STATE_WIDTH-1:0] x_max(
        input logic [PROB_BITS-1:0] f
    );
        return {f, {K{1'b0}}};
    endfunction

    state_e                 state_q, state_d;
    logic [STATE_WIDTH-1:0] x_q, x_d;
    logic [SYM_WIDTH-1:0]   ptr_q, ptr_d;
    logic [SUMW-1:0]        sum_q, sum_d;
    logic                   table_ok_q, table_ok_d;
    logic                   table_err_q, table_err_d;
    logic                   sym_err_q, sym_err_d;
    logic [PROB_BITS-1:0]   f_q, f_d;
    logic [SUMW-1:0]        c_q, c_d;
    logic [DCW-1:0]         dcnt_q, dcnt_d;
    logic [DIGIT_WIDTH-1:0] out_data_q, out_data_d;
    logic                   out_vld_q, out_vld_d;
    logic                   out_last_q, out_last_d;
    logic [PROB_BITS-1:0]   freq_q [NSYM];
    logic [PROB_BITS-1:0]   freq_d [NSYM];
    logic [SUMW-1:0]        cum_q  [NSYM];
    logic [SUMW-1:0]        cum_d  [NSYM];

    logic                   accept;
    logic                   cmd_ok;
    logic [SYM_WIDTH-1:0]   sym;
    logic [PROB_BITS-1:0]   f_sel;
    logic [SUMW-1:0]        c_sel;
    logic [SUMW-1:0]        load_base;
    logic [SUMW-1:0]        load_sum;
    logic [STATE_WIDTH-1:0] x_shr;

    logic                   div_start;
    logic [STATE_WIDTH-1:0] div_dividend;
    logic [PROB_BITS-1:0]   div_divisor;
    logic                   div_busy;
    logic                   div_done;
    logic [K-1:0]           div_quot;
    logic [PROB_BITS-1:0]   div_rem;

    ans_seq_div #(
        .DIVIDEND_W (STATE_WIDTH),
        .DIVISOR_W  (PROB_BITS)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .busy     (div_busy),
        .done     (div_done),
        .quot     (div_quot),
        .rem      (div_rem)
    );

    assign sym    = in_data[SYM_WIDTH-1:0];
    assign f_sel  = freq_q[sym];
    assign c_sel  = cum_q[sym];
    assign cmd_ok = (cmd == CMD_LOAD) || (cmd == CMD_FLUSH)
                 || ((cmd == CMD_ENC) && table_ok_q);
    assign in_rdy = !rst && (state_q == ST_IDLE) && !out_vld_q
                 && !div_busy && cmd_ok;
    assign accept = in_vld && in_rdy;

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        ptr_d        = ptr_q;
        sum_d        = sum_q;
        table_ok_d   = table_ok_q;
        table_err_d  = table_err_q;
        sym_err_d    = sym_err_q;
        f_d          = f_q;
        c_d          = c_q;
        dcnt_d       = dcnt_q;
        out_data_d   = out_data_q;
        out_vld_d    = out_vld_q;
        out_last_d   = out_last_q;
        freq_d       = freq_q;
        cum_d        = cum_q;
        div_start    = 1'b0;
        div_dividend = x_q;
        div_divisor  = f_q;
        x_shr        = x_q >> DIGIT_WIDTH;
        // Pointer at zero means this beat opens a fresh table.
        load_base    = (ptr_q == '0) ? '0 : sum_q;
        load_sum     = load_base + SUMW'(in_data);

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    unique case (cmd)
                        CMD_LOAD: begin
                            freq_d[ptr_q] = in_data;
                            cum_d[ptr_q]  = load_base;
                            sum_d         = load_sum;
                            ptr_d         = ptr_q + SYM_WIDTH'(1);
                            if (ptr_q == '0) begin
                                table_ok_d = 1'b0;
                            end
                            if (ptr_q == PTR_LAST) begin
                                table_ok_d  = (load_sum == M);
                                table_err_d = table_err_q | (load_sum != M);
                            end
                        end
                        CMD_ENC: begin
                            if (f_sel == '0) begin
                                sym_err_d = 1'b1;
                            end else begin
                                f_d = f_sel;
                                c_d = c_sel;
                                if (x_q >= x_max(f_sel)) begin
                                    state_d    = ST_RENORM;
                                    out_vld_d  = 1'b1;
                                    out_data_d = x_q[DIGIT_WIDTH-1:0];
                                    out_last_d = 1'b0;
                                end else begin
                                    state_d      = ST_DIVIDE;
                                    div_start    = 1'b1;
                                    div_dividend = x_q;
                                    div_divisor  = f_sel;
                                end
                            end
                        end
                        CMD_FLUSH: begin
                            state_d    = ST_FLUSH;
                            out_vld_d  = 1'b1;
                            out_data_d = x_q[DIGIT_WIDTH-1:0];
                            out_last_d = (NDIG == 1);
                            dcnt_d     = '0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RENORM: begin
                if (out_rdy) begin
                    x_d = x_shr;
                    if (x_shr >= x_max(f_q)) begin
                        out_data_d = x_shr[DIGIT_WIDTH-1:0];
                    end else begin
                        out_vld_d    = 1'b0;
                        state_d      = ST_DIVIDE;
                        div_start    = 1'b1;
                        div_dividend = x_shr;
                    end
                end
            end
            ST_DIVIDE: begin
                if (div_done) begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                x_d = {div_quot, {PROB_BITS{1'b0}}}
                    + STATE_WIDTH'(div_rem)
                    + STATE_WIDTH'(c_q);
                state_d = ST_IDLE;
            end
            ST_FLUSH: begin
                if (out_rdy) begin
                    if (dcnt_q == DIG_LAST) begin
                        x_d        = L;
                        out_vld_d  = 1'b0;
                        out_last_d = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        x_d        = x_shr;
                        out_data_d = x_shr[DIGIT_WIDTH-1:0];
                        dcnt_d     = dcnt_q + DCW'(1);
                        out_last_d = (dcnt_q == DIG_PEN);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            x_q         <= L;
            ptr_q       <= '0;
            sum_q       <= '0;
            table_ok_q  <= 1'b0;
            table_err_q <= 1'b0;
            sym_err_q   <= 1'b0;
            f_q         <= '0;
            c_q         <= '0;
            dcnt_q      <= '0;
            out_data_q  <= '0;
            out_vld_q   <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            ptr_q       <= ptr_d;
            sum_q       <= sum_d;
            table_ok_q  <= table_ok_d;
            table_err_q <= table_err_d;
            sym_err_q   <= sym_err_d;
            f_q         <= f_d;
            c_q         <= c_d;
            dcnt_q      <= dcnt_d;
            out_data_q  <= out_data_d;
            out_vld_q   <= out_vld_d;
            out_last_q  <= out_last_d;
        end
    end

    // Table contents need no reset; table_ok gates their use.
    always_ff @(posedge clk) begin
        freq_q <= freq_d;
        cum_q  <= cum_d;
    end

    assign out_data  = out_data_q;
    assign out_vld   = out_vld_q;
    assign out_last  = out_last_q;
    assign table_ok  = table_ok_q;
    assign table_err = table_err_q;
    assign sym_err   = sym_err_q;

endmodule

// File: tb/tb_ans_rans_encoder.sv
// Self-checking bench for ans_rans_encoder against an arithmetic rANS model.
module tb_ans_rans_encoder;
    import ans_pkg::*;

    localparam int K  = 8;
    localparam int LV = 4096;
    localparam int MV = 256;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] cmd;
    logic [7:0] in_data;
    logic       in_vld;
    logic       in_rdy;
    logic [3:0] out_data;
    logic       out_vld;
    logic       out_rdy;
    logic       out_last;
    logic       table_ok;
    logic       table_err;
    logic       sym_err;

    logic rdy_fixed = 1'b1;
    logic rdy_rand  = 1'b0;
    logic rnd_bit   = 1'b1;

    int checks = 0;
    int errors = 0;
    int freq_m [16];
    int cum_m  [16];
    int x_m;
    bit [4:0] exp_q [$];
    bit [4:0] got_q [$];

    always #5 clk = ~clk;

    assign out_rdy = rdy_rand ? rnd_bit : rdy_fixed;

    always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));

    ans_rans_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (cmd),
        .in_data   (in_data),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .out_data  (out_data),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .out_last  (out_last),
        .table_ok  (table_ok),
        .table_err (table_err),
        .sym_err   (sym_err)
    );

    // Record every digit handshake that the coming rising edge will complete.
    always @(negedge clk) begin
        if (!rst && out_vld && out_rdy) got_q.push_back({out_last, out_data});
    end

    // Normalisation interval must hold whenever the encoder is idle.
    always @(negedge clk) begin
        if (!rst && dut.state_q == ST_IDLE &&
            (int'(dut.x_q) < LV || int'(dut.x_q) >= LV * 16)) begin
            errors++;
            $display("FAIL invariant x=%0h", dut.x_q);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic void build_cum();
        int s = 0;
        for (int i = 0; i < 16; i++) begin
            cum_m[i] = s;
            s += freq_m[i];
        end
    endfunction

    function automatic int model_encode(input int s);
        int f = freq_m[s];
        int n = 0;
        exp_q.delete();
        while (x_m >= f * (1 << K)) begin
            exp_q.push_back({1'b0, 4'(x_m % 16)});
            x_m = x_m / 16;
            n++;
        end
        x_m = (x_m / f) * MV + (x_m % f) + cum_m[s];
        return n;
    endfunction

    function automatic void model_flush();
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({(i == 3) ? 1'b1 : 1'b0, 4'(x_m % 16)});
            x_m = x_m / 16;
        end
        x_m = LV;
    endfunction

    function automatic bit digits_match();
        if (got_q.size() != exp_q.size()) return 1'b0;
        foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Drive one input beat, starting just after a rising edge.
    task automatic beat(input logic [1:0] c, input logic [7:0] d);
        bit ok = 1'b0;
        cmd = c;
        in_data = d;
        in_vld = 1'b1;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            if (in_rdy) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        in_vld = 1'b0;
        cmd = CMD_IDLE;
        in_data = '0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout cmd=%0d", c);
        end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        cmd = CMD_FLUSH;
        in_vld = 1'b0;
        for (int n = 0; n < 500 && !ok; n++) begin
            @(negedge clk);
            if (in_rdy) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        cmd = CMD_IDLE;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout");
        end
    endtask

    task automatic load_table();
        build_cum();
        for (int i = 0; i < 16; i++) beat(CMD_LOAD, 8'(freq_m[i]));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd = CMD_ENC;
        in_data = '0;
        in_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        x_m = LV;
        @(negedge clk);
        checks++;
        if (out_vld !== 1'b0 || out_last !== 1'b0 || out_data !== 4'h0) begin
            errors++;
            $display("FAIL reset_out vld=%b last=%b data=%h need 0 0 0",
                     out_vld, out_last, out_data);
        end
        checks++;
        if (table_ok !== 1'b0 || table_err !== 1'b0 || sym_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags ok=%b err=%b sym=%b need 0 0 0",
                     table_ok, table_err, sym_err);
        end
        checks++;
        if (in_rdy !== 1'b0 || dut.x_q !== 16'(LV)) begin
            errors++;
            $display("FAIL reset_state rdy=%b x=%h need 0 %h",
                     in_rdy, dut.x_q, LV);
        end
        @(posedge clk);
        #1;
        cmd = CMD_IDLE;
    endtask

    task automatic test_uniform_encode();
        int n;
        int bad = 0;
        foreach (freq_m[i]) freq_m[i] = 16;
        load_table();
        @(negedge clk);
        checks++;
        if (table_ok !== 1'b1 || table_err !== 1'b0) begin
            errors++;
            $display("FAIL uniform_table ok=%b err=%b need 1 0",
                     table_ok, table_err);
        end
        for (int i = 0; i < 16; i++) if (dut.cum_q[i] !== 12'(cum_m[i])) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL uniform_cum bad_entries=%0d need 0", bad);
        end
        @(posedge clk);
        #1;
        got_q.delete();
        n = model_encode(3);
        beat(CMD_ENC, 8'd3);
        cmd = CMD_ENC;
        repeat (n + K) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_rdy !== 1'b0) begin
            errors++;
            $display("FAIL enc_latency_early rdy=%b need 0", in_rdy);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_rdy !== 1'b1 || dut.x_q !== 16'(x_m)) begin
            errors++;
            $display("FAIL enc3_done rdy=%b x=%h need 1 %h", in_rdy, dut.x_q, x_m);
        end
        checks++;
        if (!digits_match()) begin
            errors++;
            $display("FAIL enc3_digits got=%p need %p", got_q, exp_q);
        end
        @(posedge clk);
        #1;
        cmd = CMD_IDLE;
    endtask

    task automatic test_flush();
        got_q.delete();
        model_flush();
        beat(CMD_FLUSH, 8'd0);
        wait_idle();
        checks++;
        if (!digits_match()) begin
            errors++;
            $display("FAIL flush_digits got=%p need %p", got_q, exp_q);
        end
        checks++;
        if (dut.x_q !== 16'(x_m) || table_ok !== 1'b1) begin
            errors++;
            $display("FAIL flush_state x=%h ok=%b need %h 1",
                     dut.x_q, table_ok, x_m);
        end
    endtask

    task automatic test_bad_table();
        bit seen = 1'b0;
        foreach (freq_m[i]) freq_m[i] = 15;
        load_table();
        @(negedge clk);
        checks++;
        if (table_err !== 1'b1 || table_ok !== 1'b0) begin
            errors++;
            $display("FAIL bad_table err=%b ok=%b need 1 0", table_err, table_ok);
        end
        @(posedge clk);
        #1;
        cmd = CMD_ENC;
        in_data = 8'd3;
        in_vld = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (in_rdy) seen = 1'b1;
        end
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        cmd = CMD_IDLE;
        checks++;
        if (seen !== 1'b0 || dut.x_q !== 16'(x_m)) begin
            errors++;
            $display("FAIL bad_table_enc rdy_seen=%b x=%h need 0 %h",
                     seen, dut.x_q, x_m);
        end
    endtask

    task automatic test_zero_freq();
        foreach (freq_m[i]) freq_m[i] = 16;
        freq_m[0] = 0;
        freq_m[1] = 32;
        load_table();
        @(negedge clk);
        checks++;
        if (table_ok !== 1'b1 || table_err !== 1'b1 || sym_err !== 1'b0) begin
            errors++;
            $display("FAIL zf_table ok=%b err=%b sym=%b need 1 1 0",
                     table_ok, table_err, sym_err);
        end
        @(posedge clk);
        #1;
        got_q.delete();
        beat(CMD_ENC, 8'd0);
        cmd = CMD_ENC;
        @(negedge clk);
        checks++;
        if (in_rdy !== 1'b1 || sym_err !== 1'b1 || out_vld !== 1'b0) begin
            errors++;
            $display("FAIL zf_drop rdy=%b sym=%b vld=%b need 1 1 0",
                     in_rdy, sym_err, out_vld);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (got_q.size() != 0 || dut.x_q !== 16'(x_m)) begin
            errors++;
            $display("FAIL zf_state digits=%0d x=%h need 0 %h",
                     got_q.size(), dut.x_q, x_m);
        end
        @(posedge clk);
        #1;
        cmd = CMD_IDLE;
    endtask

    task automatic test_stall();
        int x0 = x_m;
        bit stable = 1'b1;
        void'(model_encode(2));
        got_q.delete();
        rdy_fixed = 1'b0;
        beat(CMD_ENC, 8'd2);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (out_vld !== 1'b1 || out_data !== exp_q[0][3:0] ||
                dut.x_q !== 16'(x0)) stable = 1'b0;
        end
        checks++;
        if (stable !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold vld=%b data=%h x=%h need 1 %h %h",
                     out_vld, out_data, dut.x_q, exp_q[0][3:0], x0);
        end
        @(posedge clk);
        #1;
        rdy_fixed = 1'b1;
        wait_idle();
        checks++;
        if (!digits_match() || dut.x_q !== 16'(x_m)) begin
            errors++;
            $display("FAIL stall_result got=%p need %p x=%h need %h",
                     got_q, exp_q, dut.x_q, x_m);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        foreach (freq_m[i]) freq_m[i] = 0;
        freq_m[0] = 1;
        freq_m[1] = 255;
        load_table();
        for (int r = 0; r < 2; r++) begin
            got_q.delete();
            n = model_encode(r);
            beat(CMD_ENC, 8'(r));
            cmd = CMD_ENC;
            repeat (n + K) @(posedge clk);
            @(negedge clk);
            checks++;
            if (in_rdy !== 1'b0) begin
                errors++;
                $display("FAIL b2b_latency_early s=%0d rdy=%b need 0", r, in_rdy);
            end
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (in_rdy !== 1'b1 || dut.x_q !== 16'(x_m) || !digits_match()) begin
                errors++;
                $display("FAIL b2b_done s=%0d rdy=%b x=%h need %h got=%p need %p",
                         r, in_rdy, dut.x_q, x_m, got_q, exp_q);
            end
            @(posedge clk);
            #1;
            cmd = CMD_IDLE;
        end
    endtask

    task automatic test_random();
        int s;
        for (int t = 0; t < 3; t++) begin
            foreach (freq_m[i]) freq_m[i] = 0;
            for (int u = 0; u < MV; u++) begin
                s = $urandom_range(0, 15);
                while (freq_m[s] >= 255) s = (s + 1) % 16;
                freq_m[s]++;
            end
            load_table();
            @(negedge clk);
            checks++;
            if (table_ok !== 1'b1) begin
                errors++;
                $display("FAIL rand_table t=%0d ok=%b need 1", t, table_ok);
            end
            @(posedge clk);
            #1;
            rdy_rand = 1'b1;
            for (int e = 0; e < 12; e++) begin
                s = $urandom_range(0, 15);
                while (freq_m[s] == 0) s = (s + 1) % 16;
                got_q.delete();
                void'(model_encode(s));
                beat(CMD_ENC, 8'(s));
                wait_idle();
                checks++;
                if (!digits_match() || dut.x_q !== 16'(x_m)) begin
                    errors++;
                    $display("FAIL rand_enc s=%0d x=%h need %h got=%p need %p",
                             s, dut.x_q, x_m, got_q, exp_q);
                end
            end
            got_q.delete();
            model_flush();
            beat(CMD_FLUSH, 8'd0);
            wait_idle();
            checks++;
            if (!digits_match() || dut.x_q !== 16'(x_m)) begin
                errors++;
                $display("FAIL rand_flush x=%h got=%p need %p",
                         dut.x_q, got_q, exp_q);
            end
            rdy_rand = 1'b0;
        end
    endtask

    task automatic test_reset_mid_divide();
        bit seen = 1'b0;
        foreach (freq_m[i]) freq_m[i] = 0;
        freq_m[0] = 1;
        freq_m[1] = 255;
        load_table();
        beat(CMD_ENC, 8'd1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_vld !== 1'b0 || table_ok !== 1'b0 || dut.x_q !== 16'(LV) ||
            in_rdy !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst vld=%b ok=%b x=%h rdy=%b need 0 0 %h 0",
                     out_vld, table_ok, dut.x_q, in_rdy, LV);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        x_m = LV;
        cmd = CMD_ENC;
        in_data = 8'd1;
        in_vld = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (in_rdy) seen = 1'b1;
        end
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        cmd = CMD_IDLE;
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_rdy seen=%b need 0", seen);
        end
        load_table();
        got_q.delete();
        void'(model_encode(1));
        beat(CMD_ENC, 8'd1);
        wait_idle();
        checks++;
        if (!digits_match() || dut.x_q !== 16'(x_m)) begin
            errors++;
            $display("FAIL mid_rst_recover x=%h need %h", dut.x_q, x_m);
        end
    endtask

    initial begin
        test_reset();
        test_uniform_encode();
        test_flush();
        test_bad_table();
        test_zero_freq();
        test_stall();
        test_back_to_back();
        test_random();
        test_reset_mid_divide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
